// File: rtl/jtbubl_sndcom_if.sv
// jtbubl_sndcom_if: main/sound CPU strobes, data and status lines of the sound communication block
interface jtbubl_sndcom_if;
    logic       main_cmd_we;
    logic       main_rpl_rd;
    logic       main_rst_we;
    logic [7:0] main_din;
    logic [7:0] main_rpl;
    logic [2:0] main_st;
    logic       snd_cmd_rd;
    logic       snd_rpl_we;
    logic       snd_nmi_on;
    logic       snd_nmi_off;
    logic [7:0] snd_din;
    logic [7:0] snd_latch;
    logic [1:0] snd_st;
    logic       snd_nmi;
    logic       snd_rst;

    modport master (
        output main_cmd_we, main_rpl_rd, main_rst_we, main_din,
               snd_cmd_rd, snd_rpl_we, snd_nmi_on, snd_nmi_off, snd_din,
        input  main_rpl, main_st, snd_latch, snd_st, snd_nmi, snd_rst
    );

    modport slave (
        input  main_cmd_we, main_rpl_rd, main_rst_we, main_din,
               snd_cmd_rd, snd_rpl_we, snd_nmi_on, snd_nmi_off, snd_din,
        output main_rpl, main_st, snd_latch, snd_st, snd_nmi, snd_rst
    );
endinterface

// File: rtl/jtbubl_sndcom.sv
// jtbubl_sndcom: main<->sound CPU mailbox with paced NMI and sound reset; JTBUBL_SNDFIFO_EN turns the command latch into a FIFO
module jtbubl_sndcom #(
    parameter int NMI_GAP = 4,
    parameter int FIFO_AW = 2
) (
    input  logic           clk,
    input  logic           rst,
    jtbubl_sndcom_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    logic [1:0] r_state;
    logic [3:0] r_gap;
    logic       r_nmi_en;
    logic       r_snd_rst;
    logic       r_ovf;
    logic       r_rfull;
    logic [7:0] r_rpl;
    logic       w_pend;
    logic       w_ovf_set;

    if (NMI_GAP < 1 || NMI_GAP > 15 || FIFO_AW < 1) begin : g_bad_param
        $error("jtbubl_sndcom: NMI_GAP must be 1..15 and FIFO_AW >= 1");
    end

`ifdef JTBUBL_SNDFIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;
    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wp;
    logic [FIFO_AW:0] r_rp;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty       = r_wp == r_rp;
    assign w_full        = (r_wp[FIFO_AW] != r_rp[FIFO_AW]) && (r_wp[FIFO_AW-1:0] == r_rp[FIFO_AW-1:0]);
    assign w_pop         = bus.snd_cmd_rd & ~w_empty;
    assign w_push        = bus.main_cmd_we & ~r_snd_rst & (~w_full | w_pop);
    assign w_ovf_set     = bus.main_cmd_we & ~r_snd_rst & w_full & ~w_pop;
    assign w_pend        = ~w_empty;
    assign bus.snd_latch = r_mem[r_rp[FIFO_AW-1:0]];

    // command FIFO; a pop frees a slot for a push in the same cycle, a held sound reset empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (r_snd_rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp[FIFO_AW-1:0]] <= bus.main_din;
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
        end
    end
`else
    logic [7:0] r_cmd;
    logic       r_pend;

    assign w_pend        = r_pend;
    assign w_ovf_set     = bus.main_cmd_we & ~r_snd_rst & r_pend & ~bus.snd_cmd_rd;
    assign bus.snd_latch = r_cmd;

    // single command latch; a write racing a read replaces the byte and keeps it pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd  <= '0;
            r_pend <= 1'b0;
        end else if (r_snd_rst) begin
            r_cmd  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (bus.main_cmd_we) r_cmd <= bus.main_din;
            r_pend <= bus.main_cmd_we | (r_pend & ~bus.snd_cmd_rd);
        end
    end
`endif

    // sticky overflow flag, cleared when the main CPU reads the reply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ovf <= 1'b0;
        else     r_ovf <= w_ovf_set | (r_ovf & ~bus.main_rpl_rd);
    end

    // reply latch; a sound write in the same cycle as a main read leaves the new byte full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rpl   <= '0;
            r_rfull <= 1'b0;
        end else if (r_snd_rst) begin
            r_rfull <= 1'b0;
        end else begin
            if (bus.snd_rpl_we) r_rpl <= bus.snd_din;
            r_rfull <= bus.snd_rpl_we | (r_rfull & ~bus.main_rpl_rd);
        end
    end

    // NMI enable and main-controlled sound CPU reset; disable wins over enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_en  <= 1'b0;
            r_snd_rst <= 1'b0;
        end else begin
            if (bus.main_rst_we) r_snd_rst <= bus.main_din[0];
            r_nmi_en <= r_snd_rst ? 1'b0 : bus.snd_nmi_off ? 1'b0 : bus.snd_nmi_on ? 1'b1 : r_nmi_en;
        end
    end

    // NMI pacing: hold the request until serviced, then stay low NMI_GAP cycles so each command gets a fresh edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
        end else if (r_snd_rst) begin
            r_state <= ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            if (w_pend & r_nmi_en) r_state <= ST_ASSERT;
        end else if (r_state == ST_ASSERT) begin
            if (bus.snd_cmd_rd | ~r_nmi_en) begin
                r_state <= ST_GAP;
                r_gap   <= 4'(NMI_GAP - 1);
            end
        end else begin
            if (r_gap == 4'd0) r_state <= ST_IDLE;
            else               r_gap   <= r_gap - 1'b1;
        end
    end

    assign bus.main_rpl = r_rpl;
    assign bus.main_st  = {r_ovf, r_rfull, w_pend};
    assign bus.snd_st   = {r_rfull, w_pend};
    assign bus.snd_nmi  = r_state == ST_ASSERT;
    assign bus.snd_rst  = r_snd_rst;
endmodule
